// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares the single-port PPU VRAM between the render fetch path and the
//   CPU register-interface path. Renderer reads normally win while a frame
//   is being drawn. A one-entry CPU holding buffer plus a wait counter
//   bound how long a CPU access can be deferred.
//
// Ports
//   clk_i, rst_ni        PPU clock, asynchronous active-low reset
//   render_active_i      frame rendering in progress
//   rnd_req_i/addr_i     renderer read request (held until rnd_ack_o)
//   rnd_ack_o/data_o     one-cycle read-complete pulse, read data
//   cpu_req_i            one-cycle request pulse; cpu_we_i/addr_i/wdata_i
//                        are sampled with it
//   cpu_busy_o           buffer occupied or CPU access in flight
//   cpu_ack_o            one-cycle CPU access-complete pulse
//   cpu_rdata_o          last CPU read data, held until the next CPU read
//   vram_addr_o/we_o     VRAM address and write enable
//   vram_data_in_o       VRAM write data
//   vram_data_out_i      VRAM read data, one cycle after the address
//
// CPU buffer states
//   state        | meaning
//   BUF_EMPTY    | no CPU access waiting; a new cpu_req_i can be latched
//   BUF_PENDING  | latched CPU access waiting for a VRAM slot

module vram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              render_active_i,
  input  logic              rnd_req_i,
  input  logic [ADDR_W-1:0] rnd_addr_i,
  output logic              rnd_ack_o,
  output logic [DATA_W-1:0] rnd_data_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_busy_o,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic              vram_we_o,
  output logic [DATA_W-1:0] vram_data_in_o,
  input  logic [DATA_W-1:0] vram_data_out_i
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic {
    BUF_EMPTY,
    BUF_PENDING
  } buf_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RND,
    GNT_CPU
  } grant_e;

  buf_state_e        buf_state_q, buf_state_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              inflight_cpu_q, inflight_cpu_d;
  logic              inflight_cpu_rd_q, inflight_cpu_rd_d;
  logic              inflight_rnd_q, inflight_rnd_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  grant_e            grant;
  logic              cpu_starved;

  assign cpu_starved = (wait_cnt_q == WAIT_LAST);

  // Grant decision. Held off while reset is asserted so a renderer request
  // cannot leak its address onto the VRAM bus during reset.
  always_comb begin
    grant = GNT_NONE;
    if (rst_ni) begin
      if ((buf_state_q == BUF_PENDING) &&
          (!render_active_i || !rnd_req_i || cpu_starved)) begin
        grant = GNT_CPU;
      end else if (rnd_req_i) begin
        grant = GNT_RND;
      end
    end
  end

  // VRAM port mux. With no grant the bus parks on the buffer address.
  always_comb begin
    vram_addr_o = buf_addr_q;
    vram_we_o   = 1'b0;
    case (grant)
      GNT_CPU: begin
        vram_addr_o = buf_addr_q;
        vram_we_o   = buf_we_q;
      end
      GNT_RND: begin
        vram_addr_o = rnd_addr_i;
      end
      default: begin
      end
    endcase
  end

  assign vram_data_in_o = buf_wdata_q;

  assign cpu_busy_o  = (buf_state_q == BUF_PENDING) | inflight_cpu_q;
  assign cpu_ack_o   = inflight_cpu_q;
  assign rnd_ack_o   = inflight_rnd_q;
  assign rnd_data_o  = vram_data_out_i;
  assign cpu_rdata_o = cpu_rdata_q;

  // CPU holding buffer and wait counter
  always_comb begin
    buf_state_d = buf_state_q;
    buf_we_d    = buf_we_q;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    case (buf_state_q)
      BUF_EMPTY: begin
        wait_cnt_d = '0;
        // cpu_busy_o also covers the ack cycle, so a request there is dropped
        if (cpu_req_i && !cpu_busy_o) begin
          buf_state_d = BUF_PENDING;
          buf_we_d    = cpu_we_i;
          buf_addr_d  = cpu_addr_i;
          buf_wdata_d = cpu_wdata_i;
        end
      end
      BUF_PENDING: begin
        if (grant == GNT_CPU) begin
          buf_state_d = BUF_EMPTY;
          wait_cnt_d  = '0;
        end else if (!cpu_starved) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        buf_state_d = BUF_EMPTY;
        wait_cnt_d  = '0;
      end
    endcase
  end

  // One-cycle in-flight flags become the acks; VRAM read data arrives in
  // the ack cycle, so a CPU read captures it at the edge ending that cycle.
  assign inflight_cpu_d    = (grant == GNT_CPU);
  assign inflight_cpu_rd_d = (grant == GNT_CPU) && !buf_we_q;
  assign inflight_rnd_d    = (grant == GNT_RND);
  assign cpu_rdata_d       = inflight_cpu_rd_q ? vram_data_out_i : cpu_rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_state_q       <= BUF_EMPTY;
      buf_we_q          <= 1'b0;
      buf_addr_q        <= '0;
      buf_wdata_q       <= '0;
      wait_cnt_q        <= '0;
      inflight_cpu_q    <= 1'b0;
      inflight_cpu_rd_q <= 1'b0;
      inflight_rnd_q    <= 1'b0;
      cpu_rdata_q       <= '0;
    end else begin
      buf_state_q       <= buf_state_d;
      buf_we_q          <= buf_we_d;
      buf_addr_q        <= buf_addr_d;
      buf_wdata_q       <= buf_wdata_d;
      wait_cnt_q        <= wait_cnt_d;
      inflight_cpu_q    <= inflight_cpu_d;
      inflight_cpu_rd_q <= inflight_cpu_rd_d;
      inflight_rnd_q    <= inflight_rnd_d;
      cpu_rdata_q       <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              render_active = 1'b0;
  logic              rnd_req = 1'b0;
  logic [ADDR_W-1:0] rnd_addr = '0;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              rnd_ack, cpu_busy, cpu_ack, vram_we;
  logic [DATA_W-1:0] rnd_data, cpu_rdata, vram_data_in;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_data_out = '0;

  logic [DATA_W-1:0] vmem    [0:65535];
  logic [DATA_W-1:0] ref_mem [0:65535];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cpu_ack_cnt = 0, rnd_ack_cnt = 0, we_cnt = 0;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .render_active_i(render_active),
    .rnd_req_i(rnd_req), .rnd_addr_i(rnd_addr), .rnd_ack_o(rnd_ack), .rnd_data_o(rnd_data),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_busy_o(cpu_busy), .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .vram_addr_o(vram_addr), .vram_we_o(vram_we), .vram_data_in_o(vram_data_in),
    .vram_data_out_i(vram_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port VRAM: read data one cycle after the address.
  always @(posedge clk) begin
    if (vram_we) vmem[vram_addr] <= vram_data_in;
    vram_data_out <= vmem[vram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a pending CPU operation with an age, acks expected in
  // the cycle after each grant, and a shadow copy of memory.
  logic              m_pend = 1'b0, m_we = 1'b0;
  int                m_age = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic              m_cpu_ack = 1'b0, m_cpu_rd = 1'b0, m_rnd_ack = 1'b0;
  logic [DATA_W-1:0] m_cpu_rd_data = '0, m_rnd_data = '0, m_cpu_rdata = '0;

  initial begin : compare
    logic cpu_win, rnd_win, busy_e;
    logic [ADDR_W-1:0] a_e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pend = 1'b0; m_age = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
        m_cpu_ack = 1'b0; m_cpu_rd = 1'b0; m_rnd_ack = 1'b0; m_cpu_rdata = '0;
        chk("rst_vram_addr", 32'(vram_addr), 32'(0));
        chk("rst_vram_we", 32'(vram_we), 32'(0));
        chk("rst_vram_data_in", 32'(vram_data_in), 32'(0));
        chk("rst_acks", 32'({rnd_ack, cpu_ack}), 32'(0));
        chk("rst_cpu_busy", 32'(cpu_busy), 32'(0));
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
      end else begin
        busy_e = m_pend || m_cpu_ack;
        chk("cpu_ack", 32'(cpu_ack), 32'(m_cpu_ack));
        chk("rnd_ack", 32'(rnd_ack), 32'(m_rnd_ack));
        if (m_rnd_ack) chk("rnd_data", 32'(rnd_data), 32'(m_rnd_data));
        chk("cpu_busy", 32'(cpu_busy), 32'(busy_e));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
        cpu_win = m_pend && (!render_active || !rnd_req || m_age == MAX_WAIT - 1);
        rnd_win = !cpu_win && rnd_req;
        a_e = rnd_win ? rnd_addr : m_addr;
        chk("vram_addr", 32'(vram_addr), 32'(a_e));
        chk("vram_we", 32'(vram_we), 32'(cpu_win && m_we));
        if (cpu_win && m_we) chk("vram_data_in", 32'(vram_data_in), 32'(m_wdata));
        if (cpu_ack) cpu_ack_cnt++;
        if (rnd_ack) rnd_ack_cnt++;
        if (vram_we) we_cnt++;
        if (m_cpu_ack && m_cpu_rd) m_cpu_rdata = m_cpu_rd_data;
        m_cpu_ack = cpu_win;
        m_cpu_rd  = cpu_win && !m_we;
        if (cpu_win) begin
          m_cpu_rd_data = ref_mem[m_addr];
          if (m_we) ref_mem[m_addr] = m_wdata;
          m_pend = 1'b0;
        end else if (m_pend) begin
          m_age++;
        end
        m_rnd_ack = rnd_win;
        if (rnd_win) m_rnd_data = ref_mem[rnd_addr];
        if (cpu_req && !busy_e) begin
          m_pend = 1'b1; m_age = 0; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
        end
      end
    end
  end

  task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, output int lat);
    int t0;
    bit seen;
    seen = 1'b0;
    lat = -1;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cpu_req = 1'b0;
      if (cpu_ack) begin
        lat = cyc - t0;
        seen = 1'b1;
        break;
      end
    end
    chk("cpu_ack_seen", 32'(seen), 32'(1));
  endtask

  task automatic rnd_stream(input int n, input logic [ADDR_W-1:0] base, output int elapsed);
    int idx, t0;
    idx = 0;
    elapsed = -1;
    @(posedge clk); #1;
    rnd_req = 1'b1; rnd_addr = base;
    t0 = cyc;
    for (int i = 0; i < n * 4 + 20; i++) begin
      @(posedge clk); #1;
      if (rnd_ack) begin
        idx++;
        if (idx == n) begin
          elapsed = cyc - t0;
          break;
        end
        rnd_addr = base + 16'(idx);
      end
    end
    rnd_req = 1'b0;
    chk("rnd_stream_done", 32'(idx), 32'(n));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, el;
    logic [DATA_W-1:0] orig;
    for (int i = 0; i < 65536; i++) begin
      vmem[i] = 8'($urandom);
      ref_mem[i] = vmem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lit_busy", 32'(cpu_busy), 32'(0));
    chk("rst_lit_addr", 32'(vram_addr), 32'(0));
    #1 rst_n = 1'b1;

    // Idle CPU write then read
    render_active = 1'b0;
    we_cnt = 0;
    cpu_access(1'b1, 16'h2000, 8'h5A, lat);
    chk("idle_wr_latency", 32'(lat), 32'(2));
    chk("idle_wr_we_pulses", 32'(we_cnt), 32'(1));
    chk("idle_wr_mem", 32'(vmem[16'h2000]), 32'(8'h5A));
    cpu_access(1'b0, 16'h2000, 8'h00, lat);
    chk("idle_rd_latency", 32'(lat), 32'(2));
    @(posedge clk); #1;
    chk("idle_rd_data", 32'(cpu_rdata), 32'(8'h5A));

    // Renderer streaming, no CPU traffic
    render_active = 1'b1;
    rnd_ack_cnt = 0;
    rnd_stream(16, 16'h2000, el);
    chk("stream_cycles", 32'(el), 32'(16));
    @(posedge clk); #1;
    chk("stream_acks", 32'(rnd_ack_cnt), 32'(16));

    // Starvation bound under continuous renderer requests
    fork
      rnd_stream(20, 16'h3000, el);
      begin
        repeat (2) @(posedge clk);
        cpu_access(1'b1, 16'h0123, 8'hC3, lat);
      end
    join
    chk("starve_latency", 32'(lat), 32'(MAX_WAIT + 1));
    chk("starve_rnd_cycles", 32'(el), 32'(21));
    chk("starve_mem", 32'(vmem[16'h0123]), 32'(8'hC3));

    // CPU takes a free slot during rendering
    repeat (2) @(posedge clk);
    cpu_access(1'b0, 16'h0123, 8'h00, lat);
    chk("free_slot_latency", 32'(lat), 32'(2));
    @(posedge clk); #1;
    chk("free_slot_rdata", 32'(cpu_rdata), 32'(8'hC3));

    // Requests while busy are dropped
    render_active = 1'b0;
    cpu_ack_cnt = 0; we_cnt = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 8'h11;
    @(posedge clk); #1;
    chk("drop_busy_pending", 32'(cpu_busy), 32'(1));
    cpu_wdata = 8'h22;
    @(posedge clk); #1;
    cpu_wdata = 8'h33;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("drop_acks", 32'(cpu_ack_cnt), 32'(1));
    chk("drop_we_pulses", 32'(we_cnt), 32'(1));
    chk("drop_mem", 32'(vmem[16'h0400]), 32'(8'h11));

    // Async reset with a CPU write pending and a renderer read in flight
    orig = vmem[16'h0500];
    render_active = 1'b1;
    @(posedge clk); #1;
    rnd_req = 1'b1; rnd_addr = 16'h2005;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0500; cpu_wdata = 8'h77;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_rnd_ack", 32'(rnd_ack), 32'(1));
    chk("pre_rst_busy", 32'(cpu_busy), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_vram_addr", 32'(vram_addr), 32'(0));
    chk("arst_vram_data_in", 32'(vram_data_in), 32'(0));
    chk("arst_rnd_ack", 32'(rnd_ack), 32'(0));
    chk("arst_busy", 32'(cpu_busy), 32'(0));
    chk("arst_cpu_rdata", 32'(cpu_rdata), 32'(0));
    @(posedge clk); #1;
    rnd_req = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    cpu_ack_cnt = 0; rnd_ack_cnt = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_acks", 32'(cpu_ack_cnt + rnd_ack_cnt), 32'(0));
    chk("post_rst_mem", 32'(vmem[16'h0500]), 32'(orig));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 49) == 0) render_active = ~render_active;
      if (!rnd_req || rnd_ack) begin
        rnd_req  = ($urandom_range(0, 3) != 0);
        rnd_addr = 16'h2000 + 16'($urandom_range(0, 31));
      end
      cpu_req   = ($urandom_range(0, 2) == 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'h2000 + 16'($urandom_range(0, 31));
      cpu_wdata = 8'($urandom);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; rnd_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port PPU VRAM between the background/sprite render fetch path and the CPU register-interface path ($2007 reads/writes). Renderer fetches have priority while a frame is being drawn. A one-entry CPU holding buffer plus a starvation counter guarantees that CPU accesses complete within a bounded number of cycles. The block sits between the renderer, the register interface and the VRAM instance, and replaces the plain address mux in the PPU top level.

## Interface
Parameters:
- ADDR_W, 16, VRAM address width
- DATA_W, 8, VRAM data width
- MAX_WAIT, 8, maximum cycles a pending CPU access may be deferred during rendering (≥1)

Ports:
- clk  in  1  PPU clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- render_active  in  1  frame rendering in progress (renderer has priority)
- rnd_req  in  1  renderer read request; held until rnd_ack
- rnd_addr  in  ADDR_W  renderer read address
- rnd_ack  out  1  one-cycle pulse: rnd_data valid
- rnd_data  out  DATA_W  read data to renderer (equals vram_data_out)
- cpu_req  in  1  one-cycle request pulse from the register interface
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  ADDR_W  CPU address; sampled with cpu_req
- cpu_wdata  in  DATA_W  CPU write data; sampled with cpu_req
- cpu_busy  out  1  buffer pending or access in flight; new cpu_req ignored
- cpu_ack  out  1  one-cycle pulse: CPU access complete
- cpu_rdata  out  DATA_W  last CPU read data, registered, held until next CPU read ack
- vram_addr  out  ADDR_W  VRAM address
- vram_we  out  1  VRAM write enable
- vram_data_in  out  DATA_W  VRAM write data
- vram_data_out  in  DATA_W  VRAM read data, valid one cycle after the address is presented

## Operation
- CPU buffer: states EMPTY, PENDING. In EMPTY with cpu_busy=0, cpu_req=1 latches cpu_we/addr/wdata and moves to PENDING. cpu_req while cpu_busy=1 is dropped with no side effects.
- Per-cycle grant decision (combinational), in priority order:
  - CPU, if PENDING and (render_active=0 or rnd_req=0 or wait_cnt==MAX_WAIT-1)
  - otherwise RND, if rnd_req=1
  - otherwise NONE
- Grant CPU: vram_addr=buffer addr; vram_we=buffer we; vram_data_in=buffer wdata; buffer returns to EMPTY; inflight_cpu set for one cycle.
- Grant RND: vram_addr=rnd_addr; vram_we=0; inflight_rnd set for one cycle.
- Grant NONE: vram_addr=buffer addr (registered, reset 0); vram_we=0.
- wait_cnt: increments each cycle the buffer is PENDING and not granted; clears on CPU grant or when EMPTY. Never exceeds MAX_WAIT-1.
- cpu_busy = PENDING | inflight_cpu.
- A renderer losing the grant keeps rnd_req/rnd_addr stable and receives no ack that cycle.

## Timing
- Reset values: vram_addr=0, vram_we=0, vram_data_in=0, rnd_ack=0, cpu_ack=0, cpu_busy=0, cpu_rdata=0, buffer EMPTY, wait_cnt=0, both inflight flags 0.
- Reset mid-operation: in-flight acks are discarded and the pending CPU access is lost; no ack follows reset deassertion.
- Renderer read granted at cycle t: rnd_ack=1 at t+1 with rnd_data=vram_data_out. Back-to-back grants give one read per cycle.
- CPU: cpu_req at t, buffer PENDING from t+1. Earliest grant is t+1, and cpu_ack is asserted at grant+1.
  - Write: VRAM written at the grant-cycle edge.
  - Read: cpu_rdata loaded from vram_data_out at the edge ending the ack cycle, and visible from ack+1.
- Worst-case CPU latency under continuous rnd_req with render_active=1: grant at latch+MAX_WAIT-1, ack at latch+MAX_WAIT.
- cpu_busy deasserts in the cycle after cpu_ack. A cpu_req in that cycle is accepted.
- vram_we is asserted for exactly one cycle per CPU write and is never asserted on RND or NONE grants.

## Test plan
- Idle CPU write then read: render_active=0, write 0x5A to 0x2000, then read 0x2000 → cpu_ack 2 cycles after each cpu_req, vram_we high 1 cycle, cpu_rdata=0x5A.
- Renderer streaming: rnd_req held, addresses 0x2000..0x200F, render_active=1, no CPU traffic → 16 rnd_ack pulses on consecutive cycles, each with matching data.
- Starvation bound: continuous rnd_req plus render_active=1, CPU write at t, MAX_WAIT=8 → CPU grant at t+8, cpu_ack at t+9, exactly one renderer ack missing in the sequence.
- CPU wins a free slot: render_active=1, rnd_req=0 when cpu_req fires → CPU grant the next cycle, wait_cnt stays 0.
- Dropped request: second cpu_req while cpu_busy=1 → ignored, single cpu_ack, VRAM holds first value only.
- Async reset with a CPU access PENDING and a renderer read in flight: reset=0 → all outputs at reset values immediately, and no ack after release.
